// File: rtl/range_finder_param.sv
// -----------------------------------------------------------------------------
// range_finder_param
//
// Tracks the minimum and maximum of a qualified sample stream between a `go`
// pulse and a `finish` pulse. At the end of a session it reports the range
// (max-min), max, min and the number of accepted samples. These results are
// held until the next completed session. A sticky error flag reports protocol
// violations.
//
// Parameters:
//   WIDTH        sample width in bits (>= 2)
//   SIGNED_DATA  1 = data_in is two's complement, 0 = unsigned
//   CNT_W        width of the saturating sample counter
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   asynchronous active-low reset
//   go            in   start a session
//   finish        in   end a session
//   data_valid    in   data_in qualifier
//   data_in       in   [WIDTH-1:0] sample
//   range         out  [WIDTH:0]   max-min, unsigned, held
//   max_out       out  [WIDTH-1:0] session maximum, held
//   min_out       out  [WIDTH-1:0] session minimum, held
//   sample_count  out  [CNT_W-1:0] accepted samples, saturating
//   result_valid  out  held result belongs to the last completed session
//   error         out  sticky protocol error
//   midpoint      out  [WIDTH-1:0] floor((max+min)/2)
//
// Optional feature macro: RANGE_FINDER_MIDPOINT_EN
//   defined   -> midpoint is registered with the other results
//   undefined -> midpoint is tied to 0 and no adder is built
// -----------------------------------------------------------------------------
module range_finder_param #(
    parameter int WIDTH       = 9,
    parameter int SIGNED_DATA = 0,
    parameter int CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    input  logic             finish,
    input  logic             data_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH:0]   range,
    output logic [WIDTH-1:0] max_out,
    output logic [WIDTH-1:0] min_out,
    output logic [CNT_W-1:0] sample_count,
    output logic             result_valid,
    output logic             error,
    output logic [WIDTH-1:0] midpoint
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Running session values
    logic [WIDTH-1:0] r_min;
    logic [WIDTH-1:0] r_max;
    logic [CNT_W-1:0] r_cnt;
    logic             r_empty;

    // Held results
    logic [WIDTH:0]   r_range;
    logic [WIDTH-1:0] r_max_out;
    logic [WIDTH-1:0] r_min_out;
    logic [CNT_W-1:0] r_count_out;
    logic             r_result_valid;
    logic             r_error;

    // Session values after this cycle's sample (if any) is folded in
    logic [WIDTH-1:0] w_upd_min;
    logic [WIDTH-1:0] w_upd_max;
    logic [CNT_W-1:0] w_upd_cnt;
    logic             w_upd_empty;
    logic [CNT_W-1:0] w_base_cnt;
    logic             w_base_empty;

    logic             w_start;
    logic             w_active;
    logic             w_take;
    logic             w_close;
    logic             w_load;
    logic             w_err_set;
    logic [WIDTH:0]   w_range;

    function automatic logic is_less(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
        if (SIGNED_DATA != 0) begin
            return $signed(a) < $signed(b);
        end
        return a < b;
    endfunction

    // Widen by one bit: sign-extend in signed mode, zero-extend otherwise
    function automatic logic [WIDTH:0] ext(input logic [WIDTH-1:0] a);
        return {((SIGNED_DATA != 0) & a[WIDTH-1]), a};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c) begin
            return c;
        end
        return c + CNT_W'(1);
    endfunction

    always_comb begin
        w_start  = (r_state == S_IDLE) && go && !finish;
        w_active = (r_state == S_ACTIVE);
        w_close  = w_active && finish;

        // A legal go starts from an empty session; the go-cycle sample
        // (if qualified) becomes the first sample.
        w_base_empty = w_start ? 1'b1 : r_empty;
        w_base_cnt   = w_start ? '0   : r_cnt;
        w_take       = data_valid && (w_start || w_active);

        w_upd_min   = r_min;
        w_upd_max   = r_max;
        w_upd_cnt   = w_base_cnt;
        w_upd_empty = w_base_empty;
        if (w_take) begin
            if (w_base_empty || is_less(data_in, r_min)) begin
                w_upd_min = data_in;
            end
            if (w_base_empty || is_less(r_max, data_in)) begin
                w_upd_max = data_in;
            end
            w_upd_cnt   = sat_inc(w_base_cnt);
            w_upd_empty = 1'b0;
        end

        // A session closing with no samples produces no result
        w_load    = w_close && !w_upd_empty;
        w_err_set = ((r_state == S_IDLE) && finish) ||
                    (w_active && go) ||
                    (w_close && w_upd_empty);

        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = S_ACTIVE;
        end else if (w_close) begin
            w_state_nxt = S_IDLE;
        end

        w_range = ext(w_upd_max) - ext(w_upd_min);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_min          <= '0;
            r_max          <= '0;
            r_cnt          <= '0;
            r_empty        <= 1'b1;
            r_range        <= '0;
            r_max_out      <= '0;
            r_min_out      <= '0;
            r_count_out    <= '0;
            r_result_valid <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_min   <= w_upd_min;
            r_max   <= w_upd_max;
            r_cnt   <= w_upd_cnt;
            r_empty <= w_upd_empty;

            if (w_start) begin
                r_error        <= 1'b0;
                r_result_valid <= 1'b0;
            end else if (w_err_set) begin
                r_error <= 1'b1;
            end

            if (w_load) begin
                r_range        <= w_range;
                r_max_out      <= w_upd_max;
                r_min_out      <= w_upd_min;
                r_count_out    <= w_upd_cnt;
                r_result_valid <= 1'b1;
            end
        end
    end

`ifdef RANGE_FINDER_MIDPOINT_EN
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] r_midpoint;

    // The sum fits in WIDTH+1 bits; dropping its LSB is the arithmetic
    // (signed) or logical (unsigned) shift right, floored toward -inf.
    assign w_sum = ext(w_upd_max) + ext(w_upd_min);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_midpoint <= '0;
        end else if (w_load) begin
            r_midpoint <= w_sum[WIDTH:1];
        end
    end

    assign midpoint = r_midpoint;
`else
    assign midpoint = '0;
`endif

    assign range        = r_range;
    assign max_out      = r_max_out;
    assign min_out      = r_min_out;
    assign sample_count = r_count_out;
    assign result_valid = r_result_valid;
    assign error        = r_error;

endmodule

// File: tb/tb_range_finder_param.sv
// -----------------------------------------------------------------------------
// Testbench for range_finder_param.
// Two instances are used:
//   dut_u: WIDTH=9, unsigned, CNT_W=8
//   dut_s: WIDTH=9, signed, CNT_W=2
// Expected session results are queued when a session is issued. A monitor pops
// and compares them each time result_valid rises.
// -----------------------------------------------------------------------------
module tb_range_finder_param;

    typedef struct {
        longint rng;
        longint mx;
        longint mn;
        longint cnt;
        longint mid;
        longint err;
    } exp_t;

    logic clk;
    logic rst_n;

    logic       u_go, u_finish, u_dv;
    logic [8:0] u_din;
    logic [9:0] u_range;
    logic [8:0] u_max, u_min, u_mid;
    logic [7:0] u_cnt;
    logic       u_rv, u_err;

    logic       s_go, s_finish, s_dv;
    logic [8:0] s_din;
    logic [9:0] s_range;
    logic [8:0] s_max, s_min, s_mid;
    logic [1:0] s_cnt;
    logic       s_rv, s_err;

    exp_t qu[$];
    exp_t qs[$];

    int n_pass = 0;
    int n_tot  = 0;

    range_finder_param #(.WIDTH(9), .SIGNED_DATA(0), .CNT_W(8)) dut_u (
        .clock(clk), .reset(rst_n), .go(u_go), .finish(u_finish),
        .data_valid(u_dv), .data_in(u_din), .range(u_range),
        .max_out(u_max), .min_out(u_min), .sample_count(u_cnt),
        .result_valid(u_rv), .error(u_err), .midpoint(u_mid)
    );

    range_finder_param #(.WIDTH(9), .SIGNED_DATA(1), .CNT_W(2)) dut_s (
        .clock(clk), .reset(rst_n), .go(s_go), .finish(s_finish),
        .data_valid(s_dv), .data_in(s_din), .range(s_range),
        .max_out(s_max), .min_out(s_min), .sample_count(s_cnt),
        .result_valid(s_rv), .error(s_err), .midpoint(s_mid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int w, input longint act,
                       input longint exp);
        longint m;
        m = (longint'(1) <<< w) - 1;
        n_tot++;
        if ((act & m) == (exp & m)) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act & m, exp & m);
        end
    endtask

    function automatic longint mid_exp(input longint v);
`ifdef RANGE_FINDER_MIDPOINT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    function automatic exp_t mk(input longint r, input longint mx,
                                input longint mn, input longint c,
                                input longint md, input longint e);
        exp_t x;
        x.rng = r; x.mx = mx; x.mn = mn; x.cnt = c; x.mid = mid_exp(md); x.err = e;
        return x;
    endfunction

    task automatic cmp_result(input string tag, input exp_t e, input int cw,
                              input longint r, input longint mx, input longint mn,
                              input longint c, input longint md, input longint er);
        chk({tag, "_range"}, 10, r, e.rng);
        chk({tag, "_max"}, 9, mx, e.mx);
        chk({tag, "_min"}, 9, mn, e.mn);
        chk({tag, "_count"}, cw, c, e.cnt);
        chk({tag, "_midpoint"}, 9, md, e.mid);
        chk({tag, "_error"}, 1, er, e.err);
    endtask

    // Monitors: compare on each rising edge of result_valid
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (u_rv && !prev) begin
                if (qu.size() == 0) begin
                    chk("u_unexpected_result", 32, qu.size(), 1);
                end else begin
                    e = qu.pop_front();
                    cmp_result("u", e, 8, u_range, u_max, u_min, u_cnt, u_mid, u_err);
                end
            end
            prev = u_rv;
        end
    end

    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (s_rv && !prev) begin
                if (qs.size() == 0) begin
                    chk("s_unexpected_result", 32, qs.size(), 1);
                end else begin
                    e = qs.pop_front();
                    cmp_result("s", e, 2, s_range, s_max, s_min, s_cnt, s_mid, s_err);
                end
            end
            prev = s_rv;
        end
    end

    task automatic step_u(input bit g, input bit f, input bit v, input int d);
        u_go = g; u_finish = f; u_dv = v; u_din = 9'(d);
        @(negedge clk);
    endtask

    task automatic step_s(input bit g, input bit f, input bit v, input int d);
        s_go = g; s_finish = f; s_dv = v; s_din = 9'(d);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        u_go = 0; u_finish = 0; u_dv = 0; u_din = '0;
        s_go = 0; s_finish = 0; s_dv = 0; s_din = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_range", 10, u_range, 0);
        chk("rst_max", 9, u_max, 0);
        chk("rst_min", 9, u_min, 0);
        chk("rst_count", 8, u_cnt, 0);
        chk("rst_rv", 1, u_rv, 0);
        chk("rst_error", 1, u_err, 0);
        chk("rst_midpoint", 9, u_mid, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Unsigned session: 100,20,450,7,300
        qu.push_back(mk(443, 450, 7, 5, 228, 0));
        step_u(1, 0, 1, 100);
        step_u(0, 0, 1, 20);
        step_u(0, 0, 1, 450);
        step_u(0, 0, 1, 7);
        step_u(0, 1, 1, 300);
        chk("t1_rv", 1, u_rv, 1);
        chk("t1_error", 1, u_err, 0);

        // go+finish together in IDLE: error, result held
        step_u(1, 1, 0, 0);
        chk("t3_error", 1, u_err, 1);
        chk("t3_rv_held", 1, u_rv, 1);
        chk("t3_range_held", 10, u_range, 443);

        // Legal go clears error and result_valid
        step_u(1, 0, 0, 0);
        chk("t3_error_clr", 1, u_err, 0);
        chk("t3_rv_clr", 1, u_rv, 0);

        // go mid-session: error, session continues
        step_u(1, 0, 0, 0);
        chk("t4_error_go", 1, u_err, 1);
        qu.push_back(mk(4, 9, 5, 2, 7, 1));
        step_u(0, 0, 1, 5);
        step_u(0, 1, 1, 9);
        chk("t4_rv", 1, u_rv, 1);

        // Session with no samples
        step_u(1, 0, 0, 0);
        chk("t4b_error_clr", 1, u_err, 0);
        step_u(0, 1, 0, 0);
        chk("t4b_error", 1, u_err, 1);
        chk("t4b_rv", 1, u_rv, 0);
        chk("t4b_range_kept", 10, u_range, 4);

        // Asynchronous reset mid-session
        step_u(1, 0, 1, 50);
        step_u(0, 0, 1, 60);
        step_u(0, 0, 1, 70);
        u_go = 0; u_finish = 0; u_dv = 0; u_din = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("t5_range", 10, u_range, 0);
        chk("t5_max", 9, u_max, 0);
        chk("t5_min", 9, u_min, 0);
        chk("t5_count", 8, u_cnt, 0);
        chk("t5_error", 1, u_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        qu.push_back(mk(0, 12, 12, 2, 12, 0));
        step_u(1, 0, 1, 12);
        step_u(0, 1, 1, 12);
        step_u(0, 0, 0, 0);

        // Signed extremes
        qs.push_back(mk(511, 255, -256, 3, -1, 0));
        step_s(1, 0, 1, -256);
        step_s(0, 0, 1, 255);
        step_s(0, 1, 1, 0);
        step_s(0, 0, 0, 0);

        // Counter saturation, then back-to-back go
        qs.push_back(mk(5, 6, 1, 3, 3, 0));
        step_s(1, 0, 1, 1);
        step_s(0, 0, 1, 2);
        step_s(0, 0, 1, 3);
        step_s(0, 0, 1, 4);
        step_s(0, 0, 1, 5);
        step_s(0, 1, 1, 6);
        chk("t6_rv", 1, s_rv, 1);
        qs.push_back(mk(4, -3, -7, 2, -5, 0));
        step_s(1, 0, 1, -3);
        chk("t6_rv_drop", 1, s_rv, 0);
        chk("t6_error", 1, s_err, 0);
        step_s(0, 0, 1, -7);
        step_s(0, 1, 0, 0);
        step_s(0, 0, 0, 0);
        step_s(0, 0, 0, 0);

        chk("u_queue_drained", 32, qu.size(), 0);
        chk("s_queue_drained", 32, qs.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/range_finder_param.md
Name: range_finder_param

Overview:
- Parametrised successor to the single-channel range finder.
- Tracks the minimum and maximum of a qualified sample stream between a `go` pulse and a `finish` pulse. Reports range (max-min), max, min and sample count with a result-valid flag and a sticky protocol-error flag.
- Adds over the previous generation: data qualifier, signed mode, count output, result hold and error classification.
- Sits between the chip I/O wrapper and the pins: `go`/`finish`/`data_in` come from `io_in`; results go to `io_out`.

Parameters:
- WIDTH, 9, sample width in bits (>=2).
- SIGNED_DATA, 0, 1 = `data_in` is two's complement; 0 = unsigned.
- CNT_W, 8, width of the sample counter (saturating).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserting low clears all state immediately; release is synchronous to `clock` upstream).
- go  input  1  start a session; sampled each cycle.
- finish  input  1  end a session; sampled each cycle.
- data_valid  input  1  `data_in` qualifier.
- data_in  input  WIDTH  sample.
- range  output  WIDTH+1  max-min, unsigned, held.
- max_out  output  WIDTH  session maximum, held.
- min_out  output  WIDTH  session minimum, held.
- sample_count  output  CNT_W  number of samples accepted, saturating at all-ones.
- result_valid  output  1  high while the held result belongs to the last completed session.
- error  output  1  sticky protocol error.
- midpoint  output  WIDTH  floor((max+min)/2); see Optional Feature.

Behaviour:
- Reset (reset=0): state=IDLE. range, max_out, min_out, sample_count, midpoint = 0; result_valid=0; error=0.
- States: IDLE, ACTIVE.
- IDLE, go=1 and finish=0:
  - Goes to ACTIVE; clears error and result_valid.
  - Clears the internal count.
  - If data_valid=1 that cycle, `data_in` is the first sample (min=max=data_in, count=1). Otherwise min/max are marked empty.
- IDLE, go=1 and finish=1: error=1, remain IDLE, results untouched.
- IDLE, finish=1 and go=0: error=1, remain IDLE.
- ACTIVE, data_valid=1: compare `data_in` against internal min/max using signed or unsigned compare per SIGNED_DATA. The first sample of an empty session loads both. count += 1, saturating.
- ACTIVE, go=1 (with or without finish): error=1; go is ignored; the session continues. If finish is also 1, the finish is still honoured.
- ACTIVE, finish=1:
  - A data_valid sample on the same cycle is included.
  - Next cycle: outputs load from the updated internal values, result_valid=1, state=IDLE. Latency from finish to result = 1 cycle.
- Zero accepted samples at finish: error=1, result_valid stays 0, outputs keep their previous values, state=IDLE.
- Arithmetic:
  - range = max-min computed in WIDTH+1 bits (sign-extend for SIGNED_DATA, zero-extend otherwise). Always non-negative, never overflows.
- Hold and clear rules:
  - Outputs hold until the next completed session.
  - result_valid drops on the next legal go.
  - error clears only on a legal go from IDLE or on reset.
- Reset mid-session: immediate return to IDLE; partial data is discarded.
- Back-to-back: go may be asserted on the cycle result_valid rises (state is already IDLE).

Optional Feature:
- Macro RANGE_FINDER_MIDPOINT_EN.
- Defined: midpoint = (max+min) computed in WIDTH+1 bits, arithmetic shift right by 1 (floor toward -inf in signed mode). Registered with the other results; reset 0.
- Undefined: the midpoint port is tied to 0 and no adder is built.

Test Plan:
1. WIDTH=9 unsigned: go with data 100, then 20, 450, 7 (data_valid=1), finish with data 300 -> next cycle range=443, max=450, min=7, count=5, result_valid=1, error=0.
2. SIGNED_DATA=1, WIDTH=9: samples -256, 255, 0 -> range=511 (10 bits), max=255, min=-256; midpoint (macro on) = -1; midpoint (macro off) = 0.
3. go and finish in the same IDLE cycle -> error=1, result_valid unchanged. Following legal go -> error=0.
4. In ACTIVE, go pulse mid-stream, then samples 5 and 9, then finish -> error=1 and result_valid=1 with range=4. Also: finish with data_valid never high -> error=1, result_valid=0.
5. Drive reset low mid-session after 3 samples -> all outputs 0 immediately (asynchronous, before the next edge). After release, a new session of samples 12 and 12 -> range=0, count=2.
6. CNT_W=2: 6 samples -> sample_count=3 (saturated). Then issue go on the cycle result_valid rises -> new session accepted, result_valid drops.
